// File: rtl/uart_pkg.sv
// Shared UART types and the 3-sample majority vote used by the receive path.
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Sample-tick divider: one tick every DIV enabled clocks, restarted by clr.
// Latency: first tick in the first enabled cycle after clr when DIV == 1, else after DIV cycles.
// Backpressure: none; free-running while en is high.
module uart_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority-vote bit sampling and parity/framing/overrun flags.
// Latency: frame is presented one cycle after the stop-bit majority point.
// Backpressure: single output register; a frame arriving while it is full and not being taken is dropped.
module uart_rx_param #(
    parameter int CLK_HZ     = 65_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    input  logic                 overrun_clr,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int TICK_DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_C    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam parity_t       PAR_MODE = parity_t'(PARITY);

    rx_state_t                state, state_nxt;
    logic                     rxd_m, rxd_s;
    logic                     tick;
    logic [SW-1:0]            s_cnt;
    logic [BW-1:0]            bit_idx;
    logic                     smp_a, smp_b;
    logic [DATA_BITS-1:0]     shreg;
    logic                     perr;
    logic                     bit_val, at_mid, at_end, exp_par, deliver;

    uart_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .en   (state != IDLE),
        .tick (tick)
    );

    assign bit_val = majority3(smp_a, smp_b, rxd_s);
    assign at_mid  = tick && (s_cnt == S_C);
    assign at_end  = tick && (s_cnt == S_LAST);
    assign exp_par = (PAR_MODE == PAR_ODD) ? ~^shreg : ^shreg;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        deliver   = 1'b0;
        unique case (state)
            IDLE:  if (!rxd_s) state_nxt = START;
            START: begin
                if (at_mid && bit_val) state_nxt = IDLE;
                else if (at_end)       state_nxt = DATA;
            end
            DATA: begin
                if (at_end && bit_idx == B_LAST)
                    state_nxt = (PAR_MODE != PAR_NONE) ? uart_pkg::PARITY : STOP;
            end
            uart_pkg::PARITY: if (at_end) state_nxt = STOP;
            STOP: begin
                // Leave at the mid-bit point so the next start edge is never missed.
                if (at_mid) begin
                    deliver   = 1'b1;
                    state_nxt = bit_val ? IDLE : BREAK;
                end
            end
            BREAK: if (rxd_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m   <= 1'b1;
            rxd_s   <= 1'b1;
            state   <= IDLE;
            s_cnt   <= '0;
            bit_idx <= '0;
            smp_a   <= 1'b1;
            smp_b   <= 1'b1;
            shreg   <= '0;
            perr    <= 1'b0;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            state <= state_nxt;
            if (state == IDLE) begin
                s_cnt   <= '0;
                bit_idx <= '0;
                perr    <= 1'b0;
            end else if (tick) begin
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
                if (s_cnt == S_A) smp_a <= rxd_s;
                if (s_cnt == S_B) smp_b <= rxd_s;
                if (state == DATA && s_cnt == S_C)
                    shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                if (state == DATA && s_cnt == S_LAST)
                    bit_idx <= (bit_idx == B_LAST) ? '0 : bit_idx + 1'b1;
                if (state == uart_pkg::PARITY && s_cnt == S_C)
                    perr <= (bit_val != exp_par);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_valid      <= 1'b1;
                rx_data       <= shreg;
                rx_parity_err <= perr;
                rx_frame_err  <= ~bit_val;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (deliver && rx_valid && !rx_ready) rx_overrun <= 1'b1;
            else if (overrun_clr)                 rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: 8N1 and 8E1 receivers at 16 clk/bit, checked against hand-computed frames.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_n = 1'b1;
    logic       rxd_e = 1'b1;
    logic       rx_ready = 1'b1;
    logic       overrun_clr = 1'b0;

    logic [7:0] n_data, e_data;
    logic       n_valid, n_perr, n_ferr, n_ovr, n_busy;
    logic       e_valid, e_perr, e_ferr, e_ovr, e_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Monitor state: cycles with valid high, cycle of last rise, last presented frame.
    int         n_hi = 0, n_rise = 0, e_hi = 0;
    logic       n_prev = 1'b0;
    logic [7:0] n_last = '0, e_last = '0;
    logic       n_lperr = 1'b0, n_lferr = 1'b0, e_lperr = 1'b0, e_lferr = 1'b0;

    uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0)) dut_n (
        .clk(clk), .rst(rst), .rxd(rxd_n), .rx_data(n_data), .rx_valid(n_valid), .rx_ready(rx_ready),
        .rx_parity_err(n_perr), .rx_frame_err(n_ferr), .rx_overrun(n_ovr), .overrun_clr(overrun_clr),
        .busy(n_busy)
    );

    uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1)) dut_e (
        .clk(clk), .rst(rst), .rxd(rxd_e), .rx_data(e_data), .rx_valid(e_valid), .rx_ready(rx_ready),
        .rx_parity_err(e_perr), .rx_frame_err(e_ferr), .rx_overrun(e_ovr), .overrun_clr(overrun_clr),
        .busy(e_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (n_valid) begin
            n_hi++;
            n_last  = n_data;
            n_lperr = n_perr;
            n_lferr = n_ferr;
            if (!n_prev) n_rise = cyc;
        end
        n_prev = n_valid;
        if (e_valid) begin
            e_hi++;
            e_last  = e_data;
            e_lperr = e_perr;
            e_lferr = e_ferr;
        end
    end

    // Drives bits[0] first, 16 clocks per bit; call and return at #1 after a posedge.
    task automatic send_bits(input bit sel, input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) rxd_e = bits[i];
            else     rxd_n = bits[i];
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (n_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", n_valid); end
        checks++; if (n_data !== 8'h00) begin failures++; $display("FAIL reset_data actual=%h expected=00", n_data); end
        checks++; if (n_perr !== 1'b0 || n_ferr !== 1'b0) begin failures++; $display("FAIL reset_flags actual=%b%b expected=00", n_perr, n_ferr); end
        checks++; if (n_ovr !== 1'b0) begin failures++; $display("FAIL reset_overrun actual=%b expected=0", n_ovr); end
        checks++; if (n_busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", n_busy); end
        checks++; if (e_busy !== 1'b0 || e_ovr !== 1'b0 || e_valid !== 1'b0) begin failures++; $display("FAIL reset_par_dut actual=%b%b%b expected=000", e_busy, e_ovr, e_valid); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_8n1();
        int h0, c0, lat;
        h0 = n_hi;
        c0 = cyc;
        send_bits(1'b0, {2'b11, 1'b1, 8'hA5, 1'b0}, 10);
        repeat (20) @(posedge clk);
        #1;
        lat = n_rise - c0;
        checks++; if (n_hi - h0 !== 1) begin failures++; $display("FAIL 8n1_pulse_len actual=%0d expected=1", n_hi - h0); end
        checks++; if (n_last !== 8'hA5) begin failures++; $display("FAIL 8n1_data actual=%h expected=a5", n_last); end
        checks++; if (n_lperr !== 1'b0) begin failures++; $display("FAIL 8n1_perr actual=%b expected=0", n_lperr); end
        checks++; if (n_lferr !== 1'b0) begin failures++; $display("FAIL 8n1_ferr actual=%b expected=0", n_lferr); end
        checks++; if (lat < 156 || lat > 158) begin failures++; $display("FAIL 8n1_latency actual=%0d expected=157", lat); end
    endtask

    task automatic test_parity();
        int h0;
        h0 = e_hi;
        send_bits(1'b1, {1'b1, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        repeat (20) @(posedge clk);
        #1;
        checks++; if (e_hi - h0 !== 1) begin failures++; $display("FAIL par_bad_count actual=%0d expected=1", e_hi - h0); end
        checks++; if (e_last !== 8'h03) begin failures++; $display("FAIL par_bad_data actual=%h expected=03", e_last); end
        checks++; if (e_lperr !== 1'b1 || e_lferr !== 1'b0) begin failures++; $display("FAIL par_bad_flags actual=%b%b expected=10", e_lperr, e_lferr); end
        h0 = e_hi;
        send_bits(1'b1, {1'b1, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        repeat (20) @(posedge clk);
        #1;
        checks++; if (e_hi - h0 !== 1) begin failures++; $display("FAIL par_ok_count actual=%0d expected=1", e_hi - h0); end
        checks++; if (e_last !== 8'h03) begin failures++; $display("FAIL par_ok_data actual=%h expected=03", e_last); end
        checks++; if (e_lperr !== 1'b0) begin failures++; $display("FAIL par_ok_perr actual=%b expected=0", e_lperr); end
    endtask

    task automatic test_glitch();
        int h0;
        h0 = n_hi;
        rxd_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (n_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_mid actual=%b expected=1", n_busy); end
        @(posedge clk);
        #1;
        checks++; if (n_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_end actual=%b expected=0", n_busy); end
        repeat (40) @(posedge clk);
        #1;
        checks++; if (n_hi !== h0 || n_valid !== 1'b0) begin failures++; $display("FAIL glitch_no_frame actual=%0d expected=0", n_hi - h0); end
        checks++; if (n_ferr !== 1'b0 || n_perr !== 1'b0 || n_ovr !== 1'b0) begin failures++; $display("FAIL glitch_flags actual=%b%b%b expected=000", n_ferr, n_perr, n_ovr); end
    endtask

    task automatic test_frame_err();
        int h0;
        h0 = n_hi;
        send_bits(1'b0, {2'b00, 1'b0, 8'h81, 1'b0}, 10);
        repeat (40) @(posedge clk);
        #1;
        checks++; if (n_busy !== 1'b1) begin failures++; $display("FAIL break_busy actual=%b expected=1", n_busy); end
        rxd_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (n_busy !== 1'b0) begin failures++; $display("FAIL break_exit actual=%b expected=0", n_busy); end
        repeat (100) @(posedge clk);
        #1;
        checks++; if (n_hi - h0 !== 1) begin failures++; $display("FAIL break_count actual=%0d expected=1", n_hi - h0); end
        checks++; if (n_last !== 8'h81) begin failures++; $display("FAIL break_data actual=%h expected=81", n_last); end
        checks++; if (n_lferr !== 1'b1 || n_lperr !== 1'b0) begin failures++; $display("FAIL break_flags actual=%b%b expected=10", n_lferr, n_lperr); end
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        send_bits(1'b0, {2'b11, 1'b1, 8'h11, 1'b0}, 10);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (n_valid !== 1'b1 || n_data !== 8'h11) begin failures++; $display("FAIL ovr_first actual=%b/%h expected=1/11", n_valid, n_data); end
        checks++; if (n_ovr !== 1'b0) begin failures++; $display("FAIL ovr_first_flag actual=%b expected=0", n_ovr); end
        send_bits(1'b0, {2'b11, 1'b1, 8'h22, 1'b0}, 10);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (n_valid !== 1'b1 || n_data !== 8'h11) begin failures++; $display("FAIL ovr_held actual=%b/%h expected=1/11", n_valid, n_data); end
        checks++; if (n_ovr !== 1'b1) begin failures++; $display("FAIL ovr_set actual=%b expected=1", n_ovr); end
        overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        overrun_clr = 1'b0;
        checks++; if (n_ovr !== 1'b0) begin failures++; $display("FAIL ovr_clear actual=%b expected=0", n_ovr); end
        checks++; if (n_valid !== 1'b1 || n_data !== 8'h11) begin failures++; $display("FAIL ovr_after_clr actual=%b/%h expected=1/11", n_valid, n_data); end
        rx_ready = 1'b1;
        @(negedge clk);
        checks++; if (n_valid !== 1'b1) begin failures++; $display("FAIL ovr_accept_cycle actual=%b expected=1", n_valid); end
        @(posedge clk);
        #1;
        checks++; if (n_valid !== 1'b0) begin failures++; $display("FAIL ovr_valid_drop actual=%b expected=0", n_valid); end
    endtask

    task automatic test_reset_mid();
        int h0;
        rx_ready = 1'b0;
        send_bits(1'b0, {2'b11, 1'b1, 8'h77, 1'b0}, 10);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (n_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pending actual=%b expected=1", n_valid); end
        send_bits(1'b0, {2'b11, 1'b1, 8'h5A, 1'b0}, 4);
        rxd_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (n_valid !== 1'b0 || n_busy !== 1'b0) begin failures++; $display("FAIL rstmid_cleared actual=%b%b expected=00", n_valid, n_busy); end
        rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        h0 = n_hi;
        send_bits(1'b0, {2'b11, 1'b1, 8'h3C, 1'b0}, 10);
        repeat (20) @(posedge clk);
        #1;
        checks++; if (n_hi - h0 !== 1) begin failures++; $display("FAIL rstmid_count actual=%0d expected=1", n_hi - h0); end
        checks++; if (n_last !== 8'h3C) begin failures++; $display("FAIL rstmid_data actual=%h expected=3c", n_last); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
